// File: rtl/deser_fila_ctrl.sv
// -----------------------------------------------------------------------------
// deser_fila_ctrl
//   Hands completed bytes from the deserializer (fast, unrelated clock) to the
//   queue `fila` (10 kHz clock). Runs entirely on the queue clock. Synchronises
//   the deserializer's byte-ready level, latches the byte, issues one enqueue
//   strobe per byte (waiting while the queue is full), and returns a 4-phase
//   acknowledge guarded by a watchdog.
//
// Ports
//   i_clk_10KHz       queue clock, all flops rising-edge
//   i_reset           synchronous, active-high
//   i_data_ready_in   deserializer byte-complete level (asynchronous)
//   i_data_in         deserializer byte, stable while ready is high
//   i_len_in          current queue occupancy
//   i_err_clr         one-cycle pulse clearing the sticky error
//   o_enqueue_out     one-cycle enqueue strobe
//   o_data_out        latched byte, valid during the strobe
//   o_ack_out         acknowledge to the deserializer
//   o_full_out        a byte is waiting for queue space
//   o_error_out       sticky acknowledge-timeout flag
//   o_enq_count       bytes enqueued, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module deser_fila_ctrl #(
    parameter int DEPTH       = 8,
    parameter int LEN_W       = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk_10KHz,
    input  logic             i_reset,
    input  logic             i_data_ready_in,
    input  logic [7:0]       i_data_in,
    input  logic [LEN_W-1:0] i_len_in,
    input  logic             i_err_clr,
    output logic             o_enqueue_out,
    output logic [7:0]       o_data_out,
    output logic             o_ack_out,
    output logic             o_full_out,
    output logic             o_error_out,
    output logic [CNT_W-1:0] o_enq_count
);

    localparam int               WD_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_ENQ,
        S_ACK,
        S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_sync;
    logic [1:0]       r_vld_pipe;
    logic             r_armed;
    logic [7:0]       r_data;
    logic [CNT_W-1:0] r_count;
    logic [WD_W-1:0]  r_wdog;
    logic             r_error;

    logic w_ready_sync;
    logic w_space;
    logic w_wd_hit;

    assign w_ready_sync = r_sync[1];
    assign w_space      = (i_len_in < DEPTH_L);
    assign w_wd_hit     = (r_wdog == WD_LAST);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge i_clk_10KHz) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // r_armed keeps a level still high from before a reset from
                // being taken as a fresh byte.
                if (w_ready_sync && r_armed) begin
                    w_next = w_space ? S_ENQ : S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (!w_ready_sync) begin
                    w_next = S_IDLE;
                end else if (w_space) begin
                    w_next = S_ENQ;
                end
            end
            S_ENQ: begin
                w_next = S_ACK;
            end
            S_ACK: begin
                if (!w_ready_sync) begin
                    w_next = S_IDLE;
                end else if (w_wd_hit) begin
                    w_next = S_ERR;
                end
            end
            S_ERR: begin
                if (!w_ready_sync) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        o_enqueue_out = 1'b0;
        o_ack_out     = 1'b0;
        o_full_out    = 1'b0;
        case (r_state)
            S_WAIT_SPACE: o_full_out    = 1'b1;
            S_ENQ:        o_enqueue_out = 1'b1;
            S_ACK:        o_ack_out     = 1'b1;
            S_ERR:        o_ack_out     = 1'b1;
            default: ;
        endcase
    end

    assign o_data_out  = r_data;
    assign o_enq_count = r_count;
    assign o_error_out = r_error;

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge i_clk_10KHz) begin
        if (i_reset) begin
            r_sync     <= 2'b00;
            r_vld_pipe <= 2'b00;
            r_armed    <= 1'b0;
            r_data     <= 8'h00;
            r_count    <= '0;
            r_wdog     <= '0;
            r_error    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_data_ready_in};
            // ready_sync reflects the real input level only once both sync
            // flops have reloaded after reset; arm on the first genuine low.
            r_vld_pipe <= {r_vld_pipe[0], 1'b1};
            if (r_vld_pipe[1] && !w_ready_sync) begin
                r_armed <= 1'b1;
            end

            // ENQ is never re-entered from itself, so this is exactly the
            // IDLE/WAIT_SPACE latch point.
            if (w_next == S_ENQ) begin
                r_data <= i_data_in;
            end

            if (r_state == S_ENQ) begin
                r_count <= r_count + CNT_W'(1);
            end

            if (r_state == S_ACK && w_ready_sync) begin
                r_wdog <= r_wdog + WD_W'(1);
            end else begin
                r_wdog <= '0;
            end

            // Setting has priority over clearing: a clear coincident with a
            // timeout (or while still in ERR) leaves the flag set.
            if (w_next == S_ERR) begin
                r_error <= 1'b1;
            end else if (i_err_clr) begin
                r_error <= 1'b0;
            end
        end
    end

endmodule

// File: doc/deser_fila_ctrl.md
Name: deser_fila_ctrl

Overview:
- Transfer controller between the deserializer (100 kHz domain) and the queue `fila` (10 kHz domain).
- Runs entirely on the 10 kHz queue clock and replaces the plain `len_out >= 8` acknowledge.
- Synchronises the deserializer's `data_ready`, latches each completed byte, and issues exactly one `enqueue` pulse per byte, with queue-full backpressure.
- Drives a 4-phase acknowledge back to the deserializer, with an acknowledge watchdog and an enqueue counter.

Parameters:
- DEPTH, 8, queue capacity in entries; enqueue is permitted only while len_in < DEPTH.
- LEN_W, 8, width of len_in.
- ACK_TIMEOUT, 16, clk_10KHz cycles `ack_out` may stay high while ready_sync is still 1 before error.
- CNT_W, 8, width of enq_count.

Ports:
- clk_10KHz  input  1  sole clock; all flops rising-edge.
- reset  input  1  synchronous, active-high.
- data_ready_in  input  1  deserializer byte-complete level, asynchronous to clk_10KHz; held until ack seen.
- data_in  input  8  deserializer byte, stable while data_ready_in=1.
- len_in  input  LEN_W  current queue occupancy from fila.
- err_clr  input  1  single-cycle pulse, clears the sticky error.
- enqueue_out  output  1  one-cycle enqueue strobe to fila.
- data_out  output  8  latched byte to fila data_in, valid during enqueue_out.
- ack_out  output  1  acknowledge to deserializer ack_in.
- full_out  output  1  high while a byte waits for queue space.
- error_out  output  1  sticky acknowledge-timeout flag.
- enq_count  output  CNT_W  total bytes enqueued, wraps modulo 2^CNT_W.

Behaviour:
- Synchroniser: two flops on data_ready_in produce ready_sync; latency 2 cycles; no other logic touches data_ready_in.
- Reset, when high at a clock edge, forces:
  - state=IDLE;
  - sync flops=0;
  - enqueue_out, ack_out, full_out, error_out = 0;
  - data_out=0, enq_count=0;
  - watchdog counter=0.
  - Reset mid-transfer abandons the byte; no enqueue is issued for it.
- FSM states: IDLE, WAIT_SPACE, ENQ, ACK, ERR.
- IDLE:
  - ready_sync=1 and len_in<DEPTH: latch data_in into data_out, go to ENQ.
  - ready_sync=1 and len_in>=DEPTH: go to WAIT_SPACE.
  - Otherwise stay.
- WAIT_SPACE:
  - full_out=1.
  - When len_in<DEPTH: latch data_in, go to ENQ.
  - If ready_sync drops while waiting (deserializer reset): go to IDLE, no enqueue.
- ENQ:
  - enqueue_out=1 for exactly this cycle.
  - enq_count increments; 2^CNT_W-1 wraps to 0.
  - Next state is always ACK.
- ACK:
  - ack_out=1; watchdog counts cycles while ready_sync=1.
  - ready_sync=0: ack_out drops next cycle, watchdog cleared, go to IDLE.
  - Watchdog reaches ACK_TIMEOUT: go to ERR.
- ERR:
  - error_out=1, ack_out held 1.
  - On ready_sync=0: go to IDLE; error_out stays 1.
- error_out:
  - Cleared only by err_clr or reset.
  - err_clr in the same cycle as a new timeout: the timeout wins and error_out stays 1.
- Full boundary:
  - The decision uses len_in as sampled in that cycle.
  - A simultaneous dequeue making space is honoured the following cycle.
  - len_in=DEPTH-1 permits exactly one enqueue.
  - No second enqueue can occur before ack completes, so the one-cycle lag in len_in after an enqueue is harmless.
- Exactly one enqueue per ready_sync rising episode; a level held high never re-enqueues.
- Throughput: minimum 5 cycles byte-to-byte, plus the deserializer's ack-to-release latency.
- data_out holds its value outside ENQ; it is changed only by the latch actions above.

Test Plan:
- Basic transfer: reset, len_in=0, data_in=0xA5, raise data_ready_in, drop it 3 cycles after ack_out rises:
  - enqueue_out pulses once, 3 cycles after the raise (2 sync + 1);
  - data_out=0xA5 during that pulse;
  - enq_count=1;
  - ack_out falls 3 cycles after the drop.
- Full queue: len_in=8, data_in=0x3C, data_ready_in=1:
  - full_out=1, no enqueue;
  - set len_in=7: enqueue_out one cycle later with data_out=0x3C, full_out=0.
- Boundary: len_in=7, two back-to-back bytes 0x11 and 0x22, len_in updated to 8 after the first:
  - 0x11 enqueued;
  - 0x22 held in WAIT_SPACE until len_in returns to 7.
- Watchdog: hold data_ready_in=1 indefinitely after one enqueue:
  - error_out=1 after 16 ack cycles, with no second enqueue;
  - release: ack_out=0, error_out still 1;
  - err_clr pulse: error_out=0.
- Wrap: 256 transfers → enq_count returns to 0x00, 256 enqueue pulses counted.
- Reset mid-op: assert reset in ENQ or ACK → all outputs 0 next edge, no enqueue afterwards until a fresh ready episode.
